// File: rtl/iir_tb_pkg.sv
// Shared types and default constants for the IIR stimulus/capture block.
// Holds the run-FSM state encoding and default width/depth/timeout values.
package iir_tb_pkg;

  localparam int DATA_W_DEF = 24;
  localparam int DEPTH_DEF  = 2048;
  localparam int TMO_DEF    = 4096;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } run_st_e;

endpackage

// File: rtl/iir_vec_ram.sv
// Single-write, single-registered-read vector RAM (contents never reset).
// Ports: i_we/i_waddr/i_wdata write port, i_raddr -> o_rdata one cycle later.
module iir_vec_ram #(
  parameter int W     = 24,
  parameter int DEPTH = 2048,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/iir_stim_capture.sv
// Plays a stored stimulus vector into a filter and checks its response
// against a stored expected vector. Ports: i_start/i_gap/i_tol run control,
// i_load_* memory load, o_stim_* out stream, i_resp_* in stream, status/counts.
module iir_stim_capture
  import iir_tb_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  parameter  int GAP_W  = 8,
  parameter  int TOL_W  = 8,
  parameter  int TMO    = TMO_DEF,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [GAP_W-1:0]  i_gap,
  input  logic [TOL_W-1:0]  i_tol,
  input  logic              i_load_we,
  input  logic [AW-1:0]     i_load_addr,
  input  logic [DATA_W-1:0] i_load_stim,
  input  logic [DATA_W-1:0] i_load_exp,
  output logic [DATA_W-1:0] o_stim_data,
  output logic              o_stim_valid,
  input  logic [DATA_W-1:0] i_resp_data,
  input  logic              i_resp_valid,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic              o_timeout,
  output logic [AW:0]       o_sent_cnt,
  output logic [AW:0]       o_resp_cnt,
  output logic [AW:0]       o_err_cnt,
  output logic [AW-1:0]     o_first_err_idx
);

  localparam int          TW     = $clog2(TMO + 1);
  localparam logic [AW:0] L_DEP  = (AW+1)'(DEPTH);
  localparam logic [AW:0] L_ONE  = (AW+1)'(1);

  run_st_e r_state, w_next;

  logic [AW:0]       r_rd_addr;
  logic [GAP_W-1:0]  r_gap;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [TOL_W-1:0]  r_tol;
  logic              r_issue_q;
  logic              r_stim_valid;
  logic [DATA_W-1:0] r_stim_data;
  logic [AW:0]       r_sent_cnt;
  logic [AW:0]       r_resp_cnt;
  logic [AW:0]       r_err_cnt;
  logic [AW-1:0]     r_first_err;
  logic              r_have_ferr;
  logic              r_timeout;
  logic [TW-1:0]     r_tmo_cnt;
  logic              r_cmp_v;
  logic              r_ovr_v;
  logic [DATA_W-1:0] r_resp_q;
  logic [AW-1:0]     r_cmp_idx;

  logic              w_busy;
  logic              w_go;
  logic              w_issue;
  logic              w_last_out;
  logic              w_resp_acc;
  logic              w_ovr;
  logic              w_ram_we;
  logic [DATA_W-1:0] w_stim_q;
  logic [DATA_W-1:0] w_exp_q;
  logic signed [DATA_W:0] w_diff;
  logic [DATA_W:0]   w_mag;
  logic              w_bad;
  logic              w_tmo_hit;
  logic              w_drain_end;

  assign w_busy   = (r_state == ST_SEND) || (r_state == ST_DRAIN);
  assign w_go     = i_start && !w_busy;
  assign w_ram_we = i_load_we && !w_busy;

  iir_vec_ram #(.W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_stim_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (i_load_addr),
    .i_wdata (i_load_stim),
    .i_raddr (r_rd_addr[AW-1:0]),
    .o_rdata (w_stim_q)
  );

  iir_vec_ram #(.W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_exp_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (i_load_addr),
    .i_wdata (i_load_exp),
    .i_raddr (r_resp_cnt[AW-1:0]),
    .o_rdata (w_exp_q)
  );

  // Read issue; the sample appears two edges later via RAM + output reg.
  assign w_issue = (r_state == ST_SEND) && (r_gap_cnt == '0)
                && (r_rd_addr != L_DEP);
  assign w_last_out = r_issue_q && (r_sent_cnt == L_DEP - L_ONE);

  assign w_resp_acc = w_busy && i_resp_valid;
  assign w_ovr      = w_resp_acc && (r_resp_cnt == L_DEP);

  // Compare stage: response and expected both registered one cycle.
  assign w_diff = $signed({r_resp_q[DATA_W-1], r_resp_q})
                - $signed({w_exp_q[DATA_W-1], w_exp_q});
  assign w_mag  = w_diff[DATA_W] ? $unsigned(-w_diff) : $unsigned(w_diff);
  assign w_bad  = r_cmp_v && (w_mag > (DATA_W+1)'(r_tol));

  assign w_tmo_hit = (r_state == ST_DRAIN) && !i_resp_valid
                  && (r_tmo_cnt == TW'(TMO - 1));
  assign w_drain_end = (r_resp_cnt == L_DEP) && !r_cmp_v && !r_ovr_v
                    && !i_resp_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (i_start) w_next = ST_SEND;
      ST_SEND:  if (w_last_out) w_next = ST_DRAIN;
      ST_DRAIN: if (w_tmo_hit || w_drain_end) w_next = ST_DONE;
      ST_DONE:  if (i_start) w_next = ST_SEND;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_addr    <= '0;
      r_gap        <= '0;
      r_gap_cnt    <= '0;
      r_tol        <= '0;
      r_issue_q    <= 1'b0;
      r_stim_valid <= 1'b0;
      r_stim_data  <= '0;
      r_sent_cnt   <= '0;
      r_resp_cnt   <= '0;
      r_err_cnt    <= '0;
      r_first_err  <= '0;
      r_have_ferr  <= 1'b0;
      r_timeout    <= 1'b0;
      r_tmo_cnt    <= '0;
      r_cmp_v      <= 1'b0;
      r_ovr_v      <= 1'b0;
      r_resp_q     <= '0;
      r_cmp_idx    <= '0;
    end else if (w_go) begin
      r_rd_addr    <= '0;
      r_gap        <= i_gap;
      r_gap_cnt    <= '0;
      r_tol        <= i_tol;
      r_issue_q    <= 1'b0;
      r_stim_valid <= 1'b0;
      r_sent_cnt   <= '0;
      r_resp_cnt   <= '0;
      r_err_cnt    <= '0;
      r_first_err  <= '0;
      r_have_ferr  <= 1'b0;
      r_timeout    <= 1'b0;
      r_tmo_cnt    <= '0;
      r_cmp_v      <= 1'b0;
      r_ovr_v      <= 1'b0;
    end else begin
      r_issue_q <= w_issue;
      if (w_issue) begin
        r_rd_addr <= r_rd_addr + L_ONE;
        r_gap_cnt <= r_gap;
      end else if (r_gap_cnt != '0) begin
        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
      end

      r_stim_valid <= r_issue_q && (r_state == ST_SEND);
      if (r_issue_q && (r_state == ST_SEND)) begin
        r_stim_data <= w_stim_q;
        r_sent_cnt  <= r_sent_cnt + L_ONE;
      end

      r_cmp_v <= w_resp_acc && !w_ovr;
      r_ovr_v <= w_ovr;
      if (w_resp_acc && !w_ovr) begin
        r_resp_q   <= i_resp_data;
        r_cmp_idx  <= r_resp_cnt[AW-1:0];
        r_resp_cnt <= r_resp_cnt + L_ONE;
      end

      if ((w_bad || r_ovr_v) && (r_err_cnt != '1))
        r_err_cnt <= r_err_cnt + L_ONE;
      if (w_bad && !r_have_ferr) begin
        r_first_err <= r_cmp_idx;
        r_have_ferr <= 1'b1;
      end

      if (r_state == ST_DRAIN && !i_resp_valid)
        r_tmo_cnt <= r_tmo_cnt + TW'(1);
      else
        r_tmo_cnt <= '0;
      if (w_tmo_hit) r_timeout <= 1'b1;
    end
  end

  assign o_stim_data     = r_stim_data;
  assign o_stim_valid    = r_stim_valid;
  assign o_busy          = w_busy;
  assign o_done          = (r_state == ST_DONE);
  assign o_pass          = o_done && (r_err_cnt == '0) && !r_timeout;
  assign o_timeout       = r_timeout;
  assign o_sent_cnt      = r_sent_cnt;
  assign o_resp_cnt      = r_resp_cnt;
  assign o_err_cnt       = r_err_cnt;
  assign o_first_err_idx = r_first_err;

endmodule

// File: tb/tb_iir_stim_capture.sv
// Directed bench for iir_stim_capture (DEPTH=16, TMO=64).
// Loopback path delays stim by 3 cycles; manual path drives custom responses.
module tb_iir_stim_capture;

  localparam int DW  = 24;
  localparam int DEP = 16;
  localparam int AW  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [7:0]    i_gap = '0;
  logic [7:0]    i_tol = '0;
  logic          i_load_we = 1'b0;
  logic [AW-1:0] i_load_addr = '0;
  logic [DW-1:0] i_load_stim = '0;
  logic [DW-1:0] i_load_exp = '0;
  logic [DW-1:0] o_stim_data;
  logic          o_stim_valid;
  logic [DW-1:0] i_resp_data;
  logic          i_resp_valid;
  logic          o_busy, o_done, o_pass, o_timeout;
  logic [AW:0]   o_sent_cnt, o_resp_cnt, o_err_cnt;
  logic [AW-1:0] o_first_err_idx;

  logic          lb_en = 1'b0;
  logic          man_v = 1'b0;
  logic [DW-1:0] man_d = '0;
  logic [2:0]    sh_v = '0;
  logic [DW-1:0] sh_d [3];

  logic [DW-1:0] m_stim [DEP];
  logic [DW-1:0] m_exp  [DEP];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    sh_v  <= {sh_v[1:0], o_stim_valid && lb_en};
    sh_d[0] <= o_stim_data;
    sh_d[1] <= sh_d[0];
    sh_d[2] <= sh_d[1];
  end

  assign i_resp_valid = lb_en ? sh_v[2] : man_v;
  assign i_resp_data  = lb_en ? sh_d[2] : man_d;

  iir_stim_capture #(
    .DATA_W(DW), .DEPTH(DEP), .GAP_W(8), .TOL_W(8), .TMO(64)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_start         (i_start),
    .i_gap           (i_gap),
    .i_tol           (i_tol),
    .i_load_we       (i_load_we),
    .i_load_addr     (i_load_addr),
    .i_load_stim     (i_load_stim),
    .i_load_exp      (i_load_exp),
    .o_stim_data     (o_stim_data),
    .o_stim_valid    (o_stim_valid),
    .i_resp_data     (i_resp_data),
    .i_resp_valid    (i_resp_valid),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_pass          (o_pass),
    .o_timeout       (o_timeout),
    .o_sent_cnt      (o_sent_cnt),
    .o_resp_cnt      (o_resp_cnt),
    .o_err_cnt       (o_err_cnt),
    .o_first_err_idx (o_first_err_idx)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic load_one(input int i);
    @(negedge clk);
    i_load_we   = 1'b1;
    i_load_addr = AW'(i);
    i_load_stim = m_stim[i];
    i_load_exp  = m_exp[i];
    @(negedge clk);
    i_load_we   = 1'b0;
  endtask

  task automatic start_run(input int gap, input int tol);
    @(negedge clk);
    i_gap   = 8'(gap);
    i_tol   = 8'(tol);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Called at the negedge right after the start edge (k=0).
  task automatic watch(input int bound, input bit noise,
                       output int first, output int last,
                       output int cnt, output logic [DW-1:0] d0);
    int k;
    k = 0; first = -1; last = -1; cnt = 0; d0 = '0;
    if (noise) begin
      i_load_we   = 1'b1;
      i_load_addr = '0;
      i_load_stim = 24'h123456;
      i_load_exp  = 24'h654321;
    end
    while (!o_done && k < bound) begin
      if (o_stim_valid) begin
        if (first < 0) d0 = o_stim_data;
        if (first < 0) first = k;
        last = k;
        cnt++;
      end
      @(negedge clk);
      k++;
    end
    i_load_we = 1'b0;
    chk("watch_done", {31'd0, o_done}, 32'd1);
  endtask

  task automatic wait_sent(input int bound);
    int k;
    k = 0;
    while (o_sent_cnt != 5'd16 && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk("wait_sent16", 32'(o_sent_cnt), 32'd16);
  endtask

  int f, l, c, k;
  logic [DW-1:0] d0;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit hit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEP; i++) begin
      m_stim[i] = 24'(i * 100003 - 800000);
      m_exp[i]  = m_stim[i];
    end

    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, o_stim_valid}, 32'd0);
    chk("rst_busy",  {31'd0, o_busy}, 32'd0);
    chk("rst_done",  {31'd0, o_done}, 32'd0);
    chk("rst_pass",  {31'd0, o_pass}, 32'd0);
    chk("rst_tmo",   {31'd0, o_timeout}, 32'd0);
    chk("rst_sent",  32'(o_sent_cnt), 32'd0);
    chk("rst_data",  32'(o_stim_data), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < DEP; i++) load_one(i);

    // gap 0 loopback
    lb_en = 1'b1;
    start_run(0, 0);
    chk("A_busy", {31'd0, o_busy}, 32'd1);
    watch(300, 1'b0, f, l, c, d0);
    chk("A_first", 32'(f), 32'd2);
    chk("A_last",  32'(l), 32'd17);
    chk("A_count", 32'(c), 32'd16);
    chk("A_d0",    32'(d0), 32'(m_stim[0]));
    chk("A_pass",  {31'd0, o_pass}, 32'd1);
    chk("A_err",   32'(o_err_cnt), 32'd0);
    chk("A_resp",  32'(o_resp_cnt), 32'd16);
    chk("A_sent",  32'(o_sent_cnt), 32'd16);
    chk("A_busy0", {31'd0, o_busy}, 32'd0);

    // gap 3, with loads attempted while busy
    start_run(3, 0);
    watch(400, 1'b1, f, l, c, d0);
    chk("B_first", 32'(f), 32'd2);
    chk("B_last",  32'(l), 32'd62);
    chk("B_count", 32'(c), 32'd16);
    chk("B_pass",  {31'd0, o_pass}, 32'd1);

    // tolerance boundary on index 5
    m_exp[5] = m_stim[5] + 24'd10;
    load_one(5);
    start_run(0, 9);
    watch(300, 1'b0, f, l, c, d0);
    chk("C9_d0",   32'(d0), 32'(m_stim[0]));
    chk("C9_err",  32'(o_err_cnt), 32'd1);
    chk("C9_fidx", 32'(o_first_err_idx), 32'd5);
    chk("C9_pass", {31'd0, o_pass}, 32'd0);
    chk("C9_done", {31'd0, o_done}, 32'd1);
    start_run(0, 10);
    watch(300, 1'b0, f, l, c, d0);
    chk("C10_err",  32'(o_err_cnt), 32'd0);
    chk("C10_pass", {31'd0, o_pass}, 32'd1);
    m_exp[5] = m_stim[5];
    load_one(5);

    // 12 responses then silence -> timeout
    lb_en = 1'b0;
    start_run(0, 0);
    wait_sent(100);
    for (int i = 0; i < 12; i++) begin
      man_v = 1'b1;
      man_d = m_stim[i];
      @(negedge clk);
    end
    man_v = 1'b0;
    k = 0;
    while (!o_done && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("D_delay", 32'(k), 32'd64);
    chk("D_tmo",   {31'd0, o_timeout}, 32'd1);
    chk("D_resp",  32'(o_resp_cnt), 32'd12);
    chk("D_err",   32'(o_err_cnt), 32'd0);
    chk("D_pass",  {31'd0, o_pass}, 32'd0);

    // 17 responses -> one overrun
    start_run(0, 0);
    chk("E_tmoclr", {31'd0, o_timeout}, 32'd0);
    wait_sent(100);
    for (int i = 0; i < 17; i++) begin
      man_v = 1'b1;
      man_d = m_stim[i % DEP];
      @(negedge clk);
    end
    man_v = 1'b0;
    k = 0;
    while (!o_done && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("E_done", {31'd0, o_done}, 32'd1);
    chk("E_err",  32'(o_err_cnt), 32'd1);
    chk("E_resp", 32'(o_resp_cnt), 32'd16);
    chk("E_tmo",  {31'd0, o_timeout}, 32'd0);
    chk("E_pass", {31'd0, o_pass}, 32'd0);

    // async reset in the middle of SEND
    lb_en = 1'b1;
    start_run(2, 0);
    repeat (10) @(negedge clk);
    chk("F_pre_busy", {31'd0, o_busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("F_busy",  {31'd0, o_busy}, 32'd0);
    chk("F_valid", {31'd0, o_stim_valid}, 32'd0);
    chk("F_sent",  32'(o_sent_cnt), 32'd0);
    chk("F_resp",  32'(o_resp_cnt), 32'd0);
    chk("F_data",  32'(o_stim_data), 32'd0);
    chk("F_done",  {31'd0, o_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // responses while idle are ignored
    lb_en = 1'b0;
    repeat (3) begin
      man_v = 1'b1;
      man_d = 24'h000abc;
      @(negedge clk);
    end
    man_v = 1'b0;
    @(negedge clk);
    chk("G_resp", 32'(o_resp_cnt), 32'd0);
    chk("G_err",  32'(o_err_cnt), 32'd0);

    lb_en = 1'b1;
    repeat (4) @(negedge clk);
    start_run(0, 0);
    watch(300, 1'b0, f, l, c, d0);
    chk("H_first", 32'(f), 32'd2);
    chk("H_d0",    32'(d0), 32'(m_stim[0]));
    chk("H_count", 32'(c), 32'd16);
    chk("H_pass",  {31'd0, o_pass}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
